// File: rtl/apb2wb_pkg.sv
// apb2wb_pkg: shared FSM state codes, legal write-strobe table and the
// strobe legality helper used by the APB-to-Wishbone PSRAM bridge.
package apb2wb_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Byte-strobe patterns the PSRAM controller can size (byte, halfword, word)
    localparam int         NUM_LEGAL_STRB = 7;
    localparam logic [3:0] LEGAL_STRB [NUM_LEGAL_STRB] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0011, 4'b1100, 4'b1111
    };

    // Returns 1 when the strobe pattern is one of the sizeable codes
    function automatic logic strb_legal(input logic [3:0] strb);
        logic legal;
        legal = 1'b0;
        for (int i = 0; i < NUM_LEGAL_STRB; i++) begin
            if (strb == LEGAL_STRB[i]) begin
                legal = 1'b1;
            end
        end
        return legal;
    endfunction

endpackage

// File: rtl/apb2wb_psram_bridge.sv
// apb2wb_psram_bridge: APB3/APB4 slave to Wishbone classic master bridge in
// front of the PSRAM controller. Each APB transfer becomes one Wishbone
// cycle; PREADY is held low until the controller acks. Write strobes the
// controller cannot size are rejected with PSLVERR and never reach Wishbone.
// Optional macro APB2WB_TIMEOUT_EN adds an ack timeout (TIMEOUT_CYCLES).
module apb2wb_psram_bridge
    import apb2wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pstrb,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i
);

    logic [1:0] state;
    // Rejected writes hold their error flag here for one cycle so that pready
    // lands two cycles after setup, same as the fastest Wishbone transfer
    logic       err_pend;

`ifdef APB2WB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // Bridge FSM with registered APB and Wishbone outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            err_pend <= 1'b0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
`ifdef APB2WB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        wb_adr_o <= paddr;
                        wb_dat_o <= pwdata;
                        wb_we_o  <= pwrite;
                        wb_sel_o <= pwrite ? pstrb : 4'b1111;
                        if (!pwrite || strb_legal(pstrb)) begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            state    <= REQ;
`ifdef APB2WB_TIMEOUT_EN
                            tmo_cnt  <= '0;
`endif
                        end else begin
                            err_pend <= (pstrb != 4'b0000);
                            state    <= RESP;
                        end
                    end
                end

                REQ: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        prdata   <= wb_we_o ? 32'h0 : wb_dat_i;
                        pslverr  <= 1'b0;
                        pready   <= 1'b1;
                        state    <= RESP;
                    end
`ifdef APB2WB_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        prdata   <= '0;
                        pslverr  <= 1'b1;
                        pready   <= 1'b1;
                        state    <= RESP;
                    end else begin
                        tmo_cnt  <= tmo_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (pready) begin
                        pready   <= 1'b0;
                        pslverr  <= 1'b0;
                        prdata   <= '0;
                        err_pend <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        pready   <= 1'b1;
                        pslverr  <= err_pend;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
